// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } addr_dec_t;

    // Byte address -> word index, flagging misaligned or out-of-range addresses.
    function automatic addr_dec_t addr_ok(input logic [31:0] addr, input int unsigned addr_w);
        addr_dec_t dec;
        dec.word = (addr >> 2) & ((32'd1 << addr_w) - 32'd1);
        dec.ok   = (addr[1:0] == 2'b00) && ((addr >> (addr_w + 32'd2)) == 32'd0);
        return dec;
    endfunction

endpackage

// File: rtl/imem_arbiter_starve_ctr.sv
// Saturating loader-starvation counter with clear/increment and an at-limit flag.
module imem_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [3:0] MaxVal = 4'(MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory scheduler: boot loader writes first, then fetch-priority
// arbitration with a bounded loader starvation window.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              ld_valid_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_ready_o,
    input  logic              ld_done_i,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              core_run_o
);

    state_e    state_q, state_d;
    logic      run_q;
    logic      rvalid_q, rvalid_d;
    logic      err_q, err_d;
    logic      cnt_clr, cnt_inc, at_max;
    addr_dec_t if_dec, ld_dec;

    imem_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .at_max_o(at_max)
    );

    always_comb begin
        if_dec      = addr_ok(if_addr_i, ADDR_W);
        ld_dec      = addr_ok(ld_addr_i, ADDR_W);
        state_d     = state_q;
        if_gnt_o    = 1'b0;
        ld_ready_o  = 1'b0;
        cnt_clr     = 1'b1;
        cnt_inc     = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Grants are held off while reset is asserted so every output reads 0.
        if (!rst_i) begin
            unique case (state_q)
                ST_BOOT: begin
                    ld_ready_o = 1'b1;
                    if (ld_done_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (if_req_i && !at_max) begin
                        if_gnt_o = 1'b1;
                    end else if (ld_valid_i) begin
                        ld_ready_o = 1'b1;
                    end
                    cnt_clr = ~ld_valid_i | ld_ready_o;
                    cnt_inc = ld_valid_i & if_req_i & ~ld_ready_o;
                end
                default: state_d = ST_BOOT;
            endcase
        end

        if (if_gnt_o && if_dec.ok) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_dec.word[ADDR_W-1:0];
        end else if (ld_ready_o && ld_valid_i && ld_dec.ok) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = ld_dec.word[ADDR_W-1:0];
            mem_wdata_o = ld_wdata_i;
        end

        rvalid_d = if_gnt_o;
        err_d    = if_gnt_o & ~if_dec.ok;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_BOOT;
            run_q    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= (state_d == ST_RUN);
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign if_rvalid_o = rvalid_q;
    assign if_err_o    = rvalid_q & err_q;
    // The macro presents read data the cycle after enable, so pass it straight through.
    assign if_rdata_o  = (rvalid_q && !err_q) ? mem_rdata_i : NOP_WORD[DATA_W-1:0];
    assign core_run_o  = run_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a write-first 1-cycle memory model.
module tb_imem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_rvalid, if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ready, ld_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              core_run;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    imem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .if_err_o   (if_err),
        .ld_valid_i (ld_valid),
        .ld_addr_i  (ld_addr),
        .ld_wdata_i (ld_wdata),
        .ld_ready_o (ld_ready),
        .ld_done_i  (ld_done),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .core_run_o (core_run)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        ld_wdata = '0;
        ld_done  = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem_rdata = '0;

        #3;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_core_run", core_run, 0);
        check("rst_rvalid", if_rvalid, 0);
        check("rst_rdata", if_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        step();
        step();
        rst = 1'b0;

        // Fetch requested during BOOT must be ignored.
        if_req  = 1'b1;
        if_addr = 32'h4;
        #1;
        check("boot_if_gnt", if_gnt, 0);
        check("boot_mem_en", mem_en, 0);
        check("boot_ld_ready", ld_ready, 1);
        check("boot_core_run", core_run, 0);

        // Boot image: three writes, the last together with ld_done.
        for (int i = 0; i < 3; i++) begin
            step();
            ld_valid = 1'b1;
            ld_addr  = 32'(i * 4);
            ld_wdata = 32'(8'h11 * (i + 1));
            ld_done  = (i == 2);
            #1;
            check("boot_we", mem_we, 1);
            check("boot_waddr", mem_addr, i);
            check("boot_wdata", mem_wdata, 32'(8'h11 * (i + 1)));
            check("boot_no_fetch", if_gnt, 0);
            check("boot_run_low", core_run, 0);
        end
        step();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        if_addr  = 32'h4;
        #1;
        check("run_core_run", core_run, 1);
        check("run_gnt_4", if_gnt, 1);
        check("run_ren_4", mem_en & ~mem_we, 1);
        check("run_raddr_4", mem_addr, 1);
        step();
        check("rvalid_4", if_rvalid, 1);
        check("rdata_4", if_rdata, 32'h22);
        check("err_4", if_err, 0);
        if_addr = 32'h8;
        #1;
        check("run_raddr_8", mem_addr, 2);
        step();
        check("rvalid_8", if_rvalid, 1);
        check("rdata_8", if_rdata, 32'h33);
        if_req = 1'b0;
        #1;
        check("idle_mem_en", mem_en, 0);
        step();
        check("idle_rvalid", if_rvalid, 0);

        // Misaligned fetch, then out-of-range fetch.
        if_req  = 1'b1;
        if_addr = 32'h2;
        #1;
        check("mis_gnt", if_gnt, 1);
        check("mis_mem_en", mem_en, 0);
        step();
        check("mis_rvalid", if_rvalid, 1);
        check("mis_err", if_err, 1);
        check("mis_rdata", if_rdata, 0);
        if_addr = 32'h400;
        #1;
        check("oor_mem_en", mem_en, 0);
        step();
        check("oor_rvalid", if_rvalid, 1);
        check("oor_err", if_err, 1);
        check("oor_rdata", if_rdata, 0);

        // Out-of-range loader write is accepted but dropped.
        if_req   = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h400;
        ld_wdata = 32'hCAFE_F00D;
        #1;
        check("ld_oor_ready", ld_ready, 1);
        check("ld_oor_mem_en", mem_en, 0);
        check("ld_oor_we", mem_we, 0);
        step();

        // Write then immediate read of the same word.
        ld_addr  = 32'h10;
        ld_wdata = 32'hDEAD_BEEF;
        #1;
        check("wr_ready", ld_ready, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 4);
        step();
        ld_valid = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        #1;
        check("rd_gnt", if_gnt, 1);
        step();
        check("rd_rdata", if_rdata, 32'hDEAD_BEEF);
        check("rd_err", if_err, 0);

        // Both requesters held: 4 fetch grants, then 1 forced loader grant, repeating.
        if_addr  = 32'h0;
        ld_valid = 1'b1;
        ld_addr  = 32'h20;
        ld_wdata = 32'h5555_AAAA;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("starve_if_gnt", if_gnt, (k % 5) != 4);
            check("starve_ld_ready", ld_ready, (k % 5) == 4);
            check("starve_we", mem_we, (k % 5) == 4);
            step();
            check("starve_rvalid", if_rvalid, (k % 5) != 4);
        end
        ld_valid = 1'b0;

        // Asynchronous reset between a fetch grant and its response.
        #1;
        check("rst_mid_gnt", if_gnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_core_run", core_run, 0);
        check("rst_mid_rvalid", if_rvalid, 0);
        step();
        check("rst_mid_rvalid_edge", if_rvalid, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_boot_gnt", if_gnt, 0);
        check("rst_mid_boot_ready", ld_ready, 1);
        step();
        check("rst_mid_rvalid_after", if_rvalid, 0);
        check("rst_mid_run_after", core_run, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port scheduler for the instruction memory, shared by two requesters: the fetch stage (read) and the boot/debug loader (write).
- Owns boot sequencing. The core stays held in BOOT while the image is written, then the block releases fetch in RUN.
- In RUN, fetch has priority. Loader writes use idle fetch cycles, with a starvation bound.
- Sits between the fetch stage, the loader port and a synchronous 1-cycle-read memory macro.

Parameters:
- ADDR_W, 8, word-address width of the memory (depth 2**ADDR_W words)
- DATA_W, 32, instruction/data word width
- STARVE_MAX, 4, consecutive denied loader cycles in RUN before the loader is forced a grant (range 1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch read request, level
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  read data valid (1 cycle after if_gnt_o)
- if_rdata_o  out  DATA_W  fetched instruction
- if_err_o  out  1  with if_rvalid_o: address was misaligned or out of range
- ld_valid_i  in  1  loader write request
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  DATA_W  loader write data
- ld_ready_o  out  1  loader write accepted (transfer = ld_valid_i & ld_ready_o)
- ld_done_i  in  1  pulse: boot image complete
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory word address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after a read enable
- core_run_o  out  1  1 in RUN; the fetch stage stalls while 0

Behaviour:
- Reset values:
  - state=BOOT, starvation counter=0.
  - All 1-bit outputs 0; if_rdata_o=0; mem_addr_o=0; mem_wdata_o=0.
  - Reset mid-operation aborts everything: a pending if_rvalid_o is dropped and a write in flight is not retried.
- Address decode:
  - word = addr[ADDR_W+1:2].
  - Invalid when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
- Per-cycle grant is combinational from the current state and inputs. At most one of if_gnt_o / ld_ready_o is 1 in any cycle.
- BOOT:
  - if_gnt_o=0.
  - ld_ready_o=1.
  - ld_done_i=1 -> RUN next cycle. A write in the same cycle as ld_done_i is still performed.
- RUN:
  - if_req_i=1 and counter<STARVE_MAX -> fetch granted.
  - Otherwise, with ld_valid_i=1 -> loader granted.
  - ld_done_i is ignored.
- Starvation counter (RUN only):
  - Increments when ld_valid_i & if_req_i & ~ld_ready_o.
  - Clears on every loader transfer, and when ld_valid_i=0.
  - Saturates at STARVE_MAX. At STARVE_MAX, the next cycle grants the loader and denies fetch.
- Fetch grant:
  - Valid address: mem_en_o=1, mem_we_o=0, mem_addr_o=word.
  - Next cycle: if_rvalid_o=1, if_rdata_o=mem_rdata_i, if_err_o=0.
  - Invalid address: memory not enabled. Next cycle: if_rvalid_o=1, if_rdata_o=0 (NOP), if_err_o=1.
  - Latency is fixed at 1 cycle; back-to-back grants give back-to-back rvalid.
- Loader transfer:
  - Valid address: mem_en_o=1, mem_we_o=1, mem_addr_o=word, mem_wdata_o=ld_wdata_i.
  - Invalid address: accepted (ld_ready_o=1) and dropped; no memory access.
- Idle cycles: mem_en_o=0, mem_we_o=0.
- Write followed by fetch of the same word on the next cycle returns the new data. The memory is write-first; no bypass is needed.
- core_run_o is registered: it is 1 from the first cycle in RUN and stays 1 until reset.

Decomposition:
- Shared package holds:
  - State encoding: ST_BOOT, ST_RUN.
  - NOP_WORD = 32'h0000_0000.
  - Function addr_ok(addr, ADDR_W) returning the valid flag and word index.
- One natural sub-module: imem_starve_ctr (saturating counter with clear/increment and an at-limit flag).
- The FSM, grant mux and response register stay in imem_arbiter.

Test Plan:
- Boot load: writes to 0x0,0x4,0x8 of 0x11,0x22,0x33, then ld_done_i.
  - mem_we_o pulses at word addresses 0,1,2.
  - core_run_o rises the cycle after ld_done_i.
  - Fetches of 0x4 then 0x8 return 0x22 then 0x33 with if_rvalid_o one cycle after each grant.
- Fetch during BOOT: if_req_i=1 before ld_done_i -> if_gnt_o stays 0 and no read is issued.
- Starvation, STARVE_MAX=4: if_req_i held 1 and ld_valid_i held 1 in RUN.
  - 4 fetch grants, then 1 loader transfer with if_gnt_o=0, then the counter clears.
  - The pattern repeats every 5 cycles.
- Invalid addresses:
  - Fetch 0x2 -> if_rvalid_o=1, if_err_o=1, rdata 0, mem_en_o=0.
  - Fetch 0x400 (ADDR_W=8) -> same response.
  - Loader write to 0x400 -> ld_ready_o=1 and no mem_we_o.
- Write-then-read: in RUN, loader writes 0xDEADBEEF to 0x10 at cycle n, fetch 0x10 at n+1 -> rdata 0xDEADBEEF at n+2.
- Reset mid-stream: assert rst_i asynchronously between a fetch grant and its rvalid.
  - if_rvalid_o never asserts.
  - core_run_o=0 and the state returns to BOOT immediately.
